dwt_sample_feeder: RTL and testbench

Upstream stage of the DWT core: accepts 32-bit samples on a valid/ready stream, buffers them in a small FIFO, and drives the core's block-level handshake (ap_start, data, read_valid). It presents one sample per rising edge of the core's ap_ready and counts out exactly FRAME_LEN samples per frame. At end of frame it drops ap_start and pulses frame_done. It replaces ad-hoc feeding logic in front of the DWT core in both simulation and hardware.

---
 rtl/dwt_feeder_pkg.sv | 22 ++
 rtl/dwt_sync_fifo.sv | 75 +++++++
 rtl/dwt_sample_feeder.sv | 162 ++++++++++++++++
 tb/tb_dwt_sample_feeder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dwt_feeder_pkg.sv
// Shared types and constants for the DWT sample feeder.
package dwt_feeder_pkg;

  // One-hot FSM encoding keeps decode trivial and makes illegal codes easy to spot.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN  = 3'b010,
    DONE = 3'b100
  } state_e;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_FRAME_LEN  = 1024;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int CNT_W          = 16;

  // True when the pop about to happen is the final one of the frame.
  function automatic logic is_last_sample(input logic [CNT_W-1:0] cnt,
                                          input logic [CNT_W-1:0] last_idx);
    return (cnt == last_idx);
  endfunction

endpackage

// File: rtl/dwt_sync_fifo.sv
// Synchronous first-word-fall-through FIFO built from a flop array.
// head is the oldest entry, head_nxt the one behind it, so the parent can
// preload its output register with the post-pop head in the same cycle.
module dwt_sync_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic [DATA_W-1:0]             head,
  output logic [DATA_W-1:0]             head_nxt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (count_r == CNT_DEPTH);
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign count     = count_r;
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head      = mem_r[rd_ptr_r];
  assign head_nxt  = mem_r[rd_ptr_r + PTR_ONE];

  // Storage array: write the incoming sample at the write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {(AW+1){1'b0}};
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/dwt_sample_feeder.sv
// Feeds buffered samples into the DWT core, one per rising edge of the
// core's ap_ready, and frames them into blocks of FRAME_LEN samples.
module dwt_sample_feeder
  import dwt_feeder_pkg::*;
#(
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              dwt_ap_start,
  input  logic              dwt_ap_ready,
  output logic [DATA_W-1:0] dwt_data,
  output logic [31:0]       dwt_read_valid,
  output logic              frame_done,
  output logic              underrun,
  output logic [CNT_W-1:0]  sample_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]    CNT_DEPTH = CW'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] SCNT_ONE  = CNT_W'(1);

  state_e            state_r;
  state_e            state_nxt_s;
  logic              ready_dl_r;
  logic              edge_s;
  logic              push_s;
  logic              pop_s;
  logic              last_pop_s;
  logic              full_s;
  logic              empty_s;
  logic [CW-1:0]     fifo_count_s;
  logic [CW-1:0]     cnt_nxt_s;
  logic [DATA_W-1:0] head_s;
  logic [DATA_W-1:0] head_nxt_s;
  logic [DATA_W-1:0] data_nxt_s;

  logic              s_ready_r;
  logic              ap_start_r;
  logic [DATA_W-1:0] dwt_data_r;
  logic              read_valid_r;
  logic              frame_done_r;
  logic              underrun_r;
  logic [CNT_W-1:0]  sample_cnt_r;

  assign edge_s     = dwt_ap_ready && !ready_dl_r;
  assign push_s     = s_valid && s_ready_r && !full_s;
  assign pop_s      = edge_s && (state_r == RUN) && !empty_s;
  assign last_pop_s = pop_s && is_last_sample(sample_cnt_r, LAST_IDX);
  assign cnt_nxt_s  = fifo_count_s + (push_s ? CNT_ONE : CNT_ZERO)
                                   - (pop_s  ? CNT_ONE : CNT_ZERO);

  dwt_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .push      (push_s),
    .push_data (s_data),
    .pop       (pop_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (fifo_count_s),
    .head      (head_s),
    .head_nxt  (head_nxt_s)
  );

  // FSM state register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable && !empty_s) state_nxt_s = RUN;
        else                    state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_pop_s) state_nxt_s = DONE;
        else            state_nxt_s = RUN;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next value of the presented sample: the head after this edge, held when empty.
  always_comb begin
    data_nxt_s = dwt_data_r;
    if (cnt_nxt_s == CNT_ZERO) begin
      data_nxt_s = dwt_data_r;
    end else if (pop_s) begin
      if (fifo_count_s == CNT_ONE) data_nxt_s = s_data;
      else                         data_nxt_s = head_nxt_s;
    end else if (empty_s) begin
      data_nxt_s = s_data;
    end else begin
      data_nxt_s = head_s;
    end
  end

  // Delay ap_ready by one cycle for rising-edge detection.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) ready_dl_r <= 1'b0;
    else        ready_dl_r <= dwt_ap_ready;
  end

  // Registered handshake outputs, computed from next state and next occupancy.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      s_ready_r    <= 1'b0;
      ap_start_r   <= 1'b0;
      read_valid_r <= 1'b0;
      frame_done_r <= 1'b0;
      dwt_data_r   <= {DATA_W{1'b0}};
    end else begin
      s_ready_r    <= (cnt_nxt_s != CNT_DEPTH);
      ap_start_r   <= (state_nxt_s == RUN);
      read_valid_r <= (state_nxt_s == RUN) && (cnt_nxt_s != CNT_ZERO);
      frame_done_r <= (state_nxt_s == DONE);
      dwt_data_r   <= data_nxt_s;
    end
  end

  // Per-frame sample counter; cleared while leaving DONE so IDLE reads zero.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)                 sample_cnt_r <= {CNT_W{1'b0}};
    else if (state_r == DONE)   sample_cnt_r <= {CNT_W{1'b0}};
    else if (pop_s)             sample_cnt_r <= sample_cnt_r + SCNT_ONE;
    else                        sample_cnt_r <= sample_cnt_r;
  end

  // Sticky underrun flag: a consume edge in RUN found nothing to pop.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)                                       underrun_r <= 1'b0;
    else if (edge_s && (state_r == RUN) && empty_s)   underrun_r <= 1'b1;
    else                                              underrun_r <= underrun_r;
  end

  assign s_ready        = s_ready_r;
  assign dwt_ap_start   = ap_start_r;
  assign dwt_data       = dwt_data_r;
  assign dwt_read_valid = {31'd0, read_valid_r};
  assign frame_done     = frame_done_r;
  assign underrun       = underrun_r;
  assign sample_cnt     = sample_cnt_r;

endmodule

// File: tb/tb_dwt_sample_feeder.sv
// Directed bench for dwt_sample_feeder with FRAME_LEN=8, FIFO_DEPTH=4.
module tb_dwt_sample_feeder;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] s_data = 32'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        dwt_ap_start;
  logic        dwt_ap_ready = 1'b0;
  logic [31:0] dwt_data;
  logic [31:0] dwt_read_valid;
  logic        frame_done;
  logic        underrun;
  logic [15:0] sample_cnt;

  int checks_cnt  = 0;
  int fail_cnt    = 0;
  int n_pushed    = 0;
  int stream_lim  = 0;
  int fd_cnt      = 0;
  bit auto_stream = 1'b0;

  dwt_sample_feeder #(
    .FRAME_LEN  (8),
    .FIFO_DEPTH (4),
    .DATA_W     (32)
  ) dut (
    .ap_clk         (ap_clk),
    .ap_rst         (ap_rst),
    .enable         (enable),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .dwt_ap_start   (dwt_ap_start),
    .dwt_ap_ready   (dwt_ap_ready),
    .dwt_data       (dwt_data),
    .dwt_read_valid (dwt_read_valid),
    .frame_done     (frame_done),
    .underrun       (underrun),
    .sample_cnt     (sample_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock: account for an accepted push, then sample 1ns after the edge.
  task automatic step();
    logic acc;
    acc = s_valid && s_ready;
    @(posedge ap_clk);
    #1;
    if (acc) n_pushed++;
    if (frame_done) fd_cnt++;
    if (auto_stream) begin
      s_data  = 32'(n_pushed);
      s_valid = (n_pushed < stream_lim);
    end
  endtask

  task automatic set_lim(input int lim);
    stream_lim = lim;
    s_data     = 32'(n_pushed);
    s_valid    = (n_pushed < stream_lim);
  endtask

  initial begin
    // ---------------- reset state ----------------
    #2 ap_rst = 1'b1;
    step();
    step();
    check_eq("rst_s_ready",  64'(s_ready), 64'd0);
    check_eq("rst_ap_start", 64'(dwt_ap_start), 64'd0);
    check_eq("rst_data",     64'(dwt_data), 64'd0);
    check_eq("rst_rvalid",   64'(dwt_read_valid), 64'd0);
    check_eq("rst_fdone",    64'(frame_done), 64'd0);
    check_eq("rst_underrun", 64'(underrun), 64'd0);
    check_eq("rst_scnt",     64'(sample_cnt), 64'd0);
    ap_rst = 1'b0;
    step();
    check_eq("rel_s_ready", 64'(s_ready), 64'd1);

    // ---------------- full FIFO: 0..3 accepted, 4 refused ----------------
    auto_stream = 1'b1;
    set_lim(5);
    repeat (4) step();
    check_eq("full_s_ready", 64'(s_ready), 64'd0);
    repeat (2) step();
    check_eq("full_s_ready_hold", 64'(s_ready), 64'd0);
    check_eq("full_count", 64'(dut.fifo_count_s), 64'd4);
    check_eq("full_idle_start", 64'(dwt_ap_start), 64'd0);

    // ---------------- full frame of 8, ap_ready every 3 cycles ----------------
    set_lim(8);
    enable = 1'b1;
    fd_cnt = 0;
    step();
    check_eq("start_latency", 64'(dwt_ap_start), 64'd1);
    check_eq("start_rvalid", 64'(dwt_read_valid), 64'd1);
    for (int p = 0; p < 8; p++) begin
      dwt_ap_ready = 1'b1;
      check_eq($sformatf("frame_data_%0d", p), 64'(dwt_data), 64'(p));
      if (p == 7) enable = 1'b0;
      step();
      dwt_ap_ready = 1'b0;
      if (p < 7) begin
        check_eq($sformatf("frame_cnt_%0d", p), 64'(sample_cnt), 64'(p + 1));
        check_eq($sformatf("frame_start_%0d", p), 64'(dwt_ap_start), 64'd1);
      end else begin
        check_eq("eof_fdone", 64'(frame_done), 64'd1);
        check_eq("eof_start_fall", 64'(dwt_ap_start), 64'd0);
      end
      step();
      step();
    end
    check_eq("eof_fdone_once", 64'(fd_cnt), 64'd1);
    check_eq("eof_idle_scnt", 64'(sample_cnt), 64'd0);
    check_eq("eof_idle_start", 64'(dwt_ap_start), 64'd0);
    check_eq("eof_fifo_empty", 64'(dut.fifo_count_s), 64'd0);

    // ---------------- underrun ----------------
    set_lim(9);
    enable = 1'b1;
    step();
    step();
    check_eq("ur_start", 64'(dwt_ap_start), 64'd1);
    check_eq("ur_data8", 64'(dwt_data), 64'd8);
    dwt_ap_ready = 1'b1;
    step();
    dwt_ap_ready = 1'b0;
    check_eq("ur_cnt1", 64'(sample_cnt), 64'd1);
    check_eq("ur_not_yet", 64'(underrun), 64'd0);
    check_eq("ur_rvalid0", 64'(dwt_read_valid), 64'd0);
    step();
    dwt_ap_ready = 1'b1;
    step();
    dwt_ap_ready = 1'b0;
    check_eq("ur_flag", 64'(underrun), 64'd1);
    check_eq("ur_cnt_hold", 64'(sample_cnt), 64'd1);
    step();
    set_lim(10);
    step();
    check_eq("ur_data9", 64'(dwt_data), 64'd9);
    check_eq("ur_rvalid1", 64'(dwt_read_valid), 64'd1);
    dwt_ap_ready = 1'b1;
    step();
    dwt_ap_ready = 1'b0;
    check_eq("ur_cnt2", 64'(sample_cnt), 64'd2);
    check_eq("ur_sticky", 64'(underrun), 64'd1);

    // ---------------- wide ap_ready: single pop ----------------
    set_lim(12);
    step();
    step();
    dwt_ap_ready = 1'b1;
    repeat (5) step();
    check_eq("wide_cnt", 64'(sample_cnt), 64'd3);
    check_eq("wide_count", 64'(dut.fifo_count_s), 64'd1);
    check_eq("wide_data", 64'(dwt_data), 64'd11);
    dwt_ap_ready = 1'b0;
    step();

    // ---------------- reset mid-RUN with the FIFO full ----------------
    set_lim(15);
    repeat (3) step();
    check_eq("mid_count", 64'(dut.fifo_count_s), 64'd4);
    check_eq("mid_start", 64'(dwt_ap_start), 64'd1);
    ap_rst = 1'b1;
    #1;
    check_eq("arst_start",  64'(dwt_ap_start), 64'd0);
    check_eq("arst_s_ready", 64'(s_ready), 64'd0);
    check_eq("arst_count",  64'(dut.fifo_count_s), 64'd0);
    check_eq("arst_scnt",   64'(sample_cnt), 64'd0);
    check_eq("arst_underrun", 64'(underrun), 64'd0);
    check_eq("arst_data",   64'(dwt_data), 64'd0);
    step();
    check_eq("arst_hold_s_ready", 64'(s_ready), 64'd0);
    ap_rst = 1'b0;
    enable = 1'b0;
    step();
    check_eq("arst_rel_s_ready", 64'(s_ready), 64'd1);
    check_eq("arst_rel_start", 64'(dwt_ap_start), 64'd0);

    // ---------------- simultaneous push/pop at occupancy 2 ----------------
    auto_stream = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'(n_pushed);
    step();
    s_data  = 32'(n_pushed);
    step();
    s_valid = 1'b0;
    enable  = 1'b1;
    fd_cnt  = 0;
    step();
    check_eq("sim_start", 64'(dwt_ap_start), 64'd1);
    check_eq("sim_occ_init", 64'(dut.fifo_count_s), 64'd2);
    for (int k = 0; k < 8; k++) begin
      dwt_ap_ready = 1'b1;
      s_valid = 1'b1;
      s_data  = 32'(n_pushed);
      check_eq($sformatf("sim_data_%0d", k), 64'(dwt_data), 64'(15 + k));
      if (k == 7) enable = 1'b0;
      step();
      dwt_ap_ready = 1'b0;
      s_valid = 1'b0;
      check_eq($sformatf("sim_occ_%0d", k), 64'(dut.fifo_count_s), 64'd2);
      step();
    end
    check_eq("sim_fdone_once", 64'(fd_cnt), 64'd1);
    check_eq("sim_next_head", 64'(dwt_data), 64'd23);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
